core_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the RV32 integer core. It drives the shared datapath through fetch, decode, execute, memory and writeback, one state per cycle. It owns the single shared memory port (instruction and data) through a req/ready handshake. It consumes the combinational decode outputs of the main control decoder and turns them into per-cycle enables, and it keeps cycle and retired-instruction counters.

---
 rtl/core_pkg.sv | 34 +++
 rtl/perf_counters.sv | 35 +++
 rtl/core_sequencer.sv | 127 ++++++++++++
 tb/tb_core_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 multi-cycle sequencer and control decoder.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_TRAP   = 2'b11;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_OP)     || (op == OP_IMM)    ||
               (op == OP_LOAD)   || (op == OP_STORE)  ||
               (op == OP_BRANCH) || (op == OP_JAL)    ||
               (op == OP_JALR);
    endfunction

endpackage

// File: rtl/perf_counters.sv
// Free-running cycle counter and retired-instruction counter.
module perf_counters
    import core_pkg::*;
#(
    parameter logic [31:0] CYCLE_RST   = 32'd0,
    parameter logic [31:0] INSTRET_RST = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    // Both counters wrap naturally at 32 bits.
    assign cycle_d   = cycle_q + 32'd1;
    assign instret_d = retire ? instret_q + 32'd1 : instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= CYCLE_RST;
            instret_q <= INSTRET_RST;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer owning the shared memory port.
module core_sequencer
    import core_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        branch,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        trap,
    output logic        busy,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    state_e state_q, state_d;
    logic   retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = PC_PLUS4;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        trap     = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_legal(opcode)) begin
                    state_d = S_EXEC;
                end else if (TRAP_ON_ILLEGAL) begin
                    state_d = S_TRAP;
                end else begin
                    retire = 1'b1;
                end
            end
            S_EXEC: begin
                if (branch) begin
                    pc_write = branch_taken;
                    pc_sel   = PC_BRANCH;
                    retire   = 1'b1;
                end else if (jump) begin
                    pc_write = 1'b1;
                    pc_sel   = PC_JUMP;
                    state_d  = S_WB;
                end else if (mem_read || mem_write) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = mem_write;
                if (mem_ready) begin
                    if (mem_read) state_d = S_WB;
                    else          retire  = 1'b1;
                end
            end
            S_WB: begin
                rf_we  = reg_write;
                wb_sel = jump;
                retire = 1'b1;
            end
            S_TRAP: begin
                trap     = 1'b1;
                pc_write = 1'b1;
                pc_sel   = PC_TRAP;
                state_d  = run ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // run only matters at instruction boundaries
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    assign busy = (state_q != S_IDLE);

    perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .retire      (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-instruction latency and strobe counts.
module tb_core_sequencer;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst, run, reg_write, mem_read, mem_write;
    logic        branch, jump, branch_taken, mem_ready;
    logic [6:0]  opcode;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_write;
    logic [1:0]  pc_sel;
    logic        rf_we, wb_sel, trap, busy;
    logic [31:0] cycle_cnt, instret_cnt;

    logic        mem_req1, mem_we1, addr_sel1, ir_load1, pc_write1;
    logic [1:0]  pc_sel1;
    logic        rf_we1, wb_sel1, trap1, busy1;
    logic [31:0] cycle_cnt1, instret_cnt1;

    logic        wrap_ret;
    logic [31:0] wrap_cyc, wrap_ret_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    core_sequencer #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_load(ir_load), .pc_write(pc_write),
        .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .trap(trap),
        .busy(busy), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    core_sequencer #(.TRAP_ON_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req1), .mem_we(mem_we1),
        .addr_sel(addr_sel1), .ir_load(ir_load1), .pc_write(pc_write1),
        .pc_sel(pc_sel1), .rf_we(rf_we1), .wb_sel(wb_sel1), .trap(trap1),
        .busy(busy1), .cycle_cnt(cycle_cnt1), .instret_cnt(instret_cnt1)
    );

    perf_counters #(
        .CYCLE_RST  (32'hFFFF_FFFF),
        .INSTRET_RST(32'hFFFF_FFFF)
    ) u_wrap (
        .clk(clk), .rst(rst), .retire(wrap_ret),
        .cycle_cnt(wrap_cyc), .instret_cnt(wrap_ret_cnt)
    );

    typedef struct {
        int cyc;
        int req;
        int asel;
        int we;
        int rfwe;
        int wbs;
        int trp;
        int pcw;
        int pcs3;
        int dret;
        int trp1;
        int dret1;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_dec(input logic [6:0] op, input logic rw, input logic mr,
                           input logic mw, input logic br, input logic jp,
                           input logic tk);
        opcode = op; reg_write = rw; mem_read = mr; mem_write = mw;
        branch = br; jump = jp; branch_taken = tk;
    endtask

    task automatic do_instr(input string nm, input int fw, input int dw, input exp_t e);
        exp_t  x;
        exp_t  o;
        int    fl, dl, n;
        bit    done;
        logic [31:0] ir0, ir1;
        sb.push_back(e);
        o = '{default: 0};
        ir0 = instret_cnt; ir1 = instret_cnt1;
        fl = fw; dl = dw; n = 0; done = 1'b0;
        run = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        while (!done && n < 40) begin
            if (mem_req && !addr_sel && fl > 0) begin
                mem_ready = 1'b0; fl--;
            end else if (mem_req && addr_sel && dl > 0) begin
                mem_ready = 1'b0; dl--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            if (trap1) o.trp1++;
            if (!busy) begin
                done = 1'b1;
            end else begin
                n++;
                if (mem_req) o.req++;
                if (mem_req && addr_sel) o.asel++;
                if (mem_req && mem_we) o.we++;
                if (rf_we) o.rfwe++;
                if (rf_we && wb_sel) o.wbs++;
                if (trap) o.trp++;
                if (pc_write) o.pcw++;
                if (n == 3) o.pcs3 = int'(pc_sel);
                @(posedge clk); #1;
            end
        end
        o.cyc = n;
        o.dret = int'(instret_cnt - ir0);
        o.dret1 = int'(instret_cnt1 - ir1);
        if (!done) chk({nm, " timeout"}, 0, 1);
        x = sb.pop_front();
        chk({nm, " cycles"}, o.cyc, x.cyc);
        chk({nm, " mem_req"}, o.req, x.req);
        chk({nm, " addr_sel"}, o.asel, x.asel);
        chk({nm, " mem_we"}, o.we, x.we);
        chk({nm, " rf_we"}, o.rfwe, x.rfwe);
        chk({nm, " wb_sel"}, o.wbs, x.wbs);
        chk({nm, " trap"}, o.trp, x.trp);
        chk({nm, " pc_write"}, o.pcw, x.pcw);
        chk({nm, " pc_sel@3"}, o.pcs3, x.pcs3);
        chk({nm, " instret"}, o.dret, x.dret);
        chk({nm, " trap nt"}, o.trp1, x.trp1);
        chk({nm, " instret nt"}, o.dret1, x.dret1);
    endtask

    function automatic exp_t mk(int cyc, int req, int asel, int we, int rfwe,
                                int wbs, int trp, int pcw, int pcs3, int dret,
                                int dret1);
        exp_t e;
        e.cyc = cyc; e.req = req; e.asel = asel; e.we = we; e.rfwe = rfwe;
        e.wbs = wbs; e.trp = trp; e.pcw = pcw; e.pcs3 = pcs3; e.dret = dret;
        e.trp1 = 0; e.dret1 = dret1;
        return e;
    endfunction

    initial begin
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; wrap_ret = 1'b0;
        set_dec(OP_OP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst pc_write", pc_write, 0);
        chk("rst pc_sel", pc_sel, 0);
        chk("rst cycle", cycle_cnt, 0);
        chk("rst instret", instret_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("cycle after 5", cycle_cnt, 5);

        set_dec(OP_OP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr("add", 0, 0, mk(4, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1));
        chk("instret after add", instret_cnt, 1);

        set_dec(OP_IMM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr("addi fw2", 2, 0, mk(6, 3, 0, 0, 1, 0, 0, 1, 0, 1, 1));

        set_dec(OP_LOAD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr("lw", 0, 0, mk(5, 2, 1, 0, 1, 0, 0, 1, 0, 1, 1));
        do_instr("lw dw3", 0, 3, mk(8, 5, 4, 0, 1, 0, 0, 1, 0, 1, 1));

        set_dec(OP_STORE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_instr("sw", 0, 0, mk(4, 2, 1, 1, 0, 0, 0, 1, 0, 1, 1));

        set_dec(OP_BRANCH, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_instr("beq nt", 0, 0, mk(3, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        set_dec(OP_BRANCH, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        do_instr("beq t", 0, 0, mk(3, 1, 0, 0, 0, 0, 0, 2, 1, 1, 1));

        set_dec(OP_JAL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr("jal", 0, 0, mk(4, 1, 0, 0, 1, 1, 0, 2, 2, 1, 1));
        set_dec(OP_JALR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr("jalr", 0, 0, mk(4, 1, 0, 0, 1, 1, 0, 2, 2, 1, 1));

        set_dec(7'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr("illegal", 0, 0, mk(3, 1, 0, 0, 0, 0, 1, 2, 3, 0, 1));

        set_dec(OP_OP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("fetch wait req", mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort mem_req", mem_req, 0);
        chk("abort ir_load", ir_load, 0);
        chk("abort pc_write", pc_write, 0);
        chk("abort instret", instret_cnt, 0);

        @(posedge clk); #1;
        chk("wrap preload", wrap_ret_cnt, 32'hFFFF_FFFF);
        wrap_ret = 1'b1;
        @(posedge clk); #1;
        wrap_ret = 1'b0;
        chk("instret wrap", wrap_ret_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
